// File: rtl/narrow_saturate.sv
// Two-stage elastic pipeline narrowing 32-bit values to 16 bits with signed/unsigned
// saturation or truncation, an overflow flag per result and a sticky overflow counter.
module narrow_saturate (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] data_i,
   input  logic [2:0]  mode_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [15:0] data_o,
   output logic        ovf_o,
   input  logic        clr_cnt_i,
   output logic [7:0]  ovf_cnt_o
);

   localparam logic [2:0] MODE_USAT  = 3'b001;
   localparam logic [2:0] MODE_TRUNC = 3'b010;

   logic        r_s1_valid;
   logic [31:0] r_s1_data;
   logic [2:0]  r_s1_mode;
   logic        r_s2_valid;
   logic [15:0] r_s2_data;
   logic        r_s2_ovf;
   logic [7:0]  r_cnt;

   logic [16:0] w_hi;
   logic [15:0] w_nar_data;
   logic        w_nar_ovf;
   logic        w_s1_load;
   logic        w_s2_load;
   logic        w_out_acc;

   assign in_ready_o  = rst_i && (!r_s1_valid || !r_s2_valid || out_ready_i);
   assign w_s1_load   = in_valid_i && in_ready_o;
   assign w_s2_load   = r_s1_valid && (!r_s2_valid || out_ready_i);
   assign w_out_acc   = r_s2_valid && out_ready_i;
   assign w_hi        = r_s1_data[31:15];

   assign out_valid_o = r_s2_valid;
   assign data_o      = r_s2_data;
   assign ovf_o       = r_s2_ovf;
   assign ovf_cnt_o   = r_cnt;

   // Signed range holds when bits [31:15] are a pure sign extension.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      w_nar_data = r_s1_data[15:0];
      w_nar_ovf  = 1'b0;
      case (r_s1_mode)
         MODE_USAT: begin
            if (|r_s1_data[31:16]) begin
               w_nar_data = 16'hFFFF;
               w_nar_ovf  = 1'b1;
            end
         end
         MODE_TRUNC: begin
            w_nar_ovf = 1'b0;
         end
         default: begin
            if (!(&w_hi || ~|w_hi)) begin
               w_nar_data = r_s1_data[31] ? 16'h8000 : 16'h7FFF;
               w_nar_ovf  = 1'b1;
            end
         end
      endcase
   end

   // NOTE: payload registers carry no reset; the valid bits alone decide whether they mean anything.
   always_ff @(posedge clk_i) begin
      if (w_s1_load) begin
         r_s1_data <= data_i;
         r_s1_mode <= mode_i;
      end
   end

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2_data  <= 16'h0000;
         r_s2_ovf   <= 1'b0;
         r_cnt      <= 8'h00;
      end else begin
         if (w_s1_load)
            r_s1_valid <= 1'b1;
         else if (w_s2_load)
            r_s1_valid <= 1'b0;

         if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_s2_data  <= w_nar_data;
            r_s2_ovf   <= w_nar_ovf;
         end else if (out_ready_i) begin
            r_s2_valid <= 1'b0;
         end

         // Clear wins over a simultaneous overflow acceptance; count sticks at 8'hFF.
         if (clr_cnt_i)
            r_cnt <= 8'h00;
         else if (w_out_acc && r_s2_ovf && r_cnt != 8'hFF)
            r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_narrow_saturate.sv
// Directed plus short random bench for narrow_saturate; expected results flow through
// a scoreboard queue filled at input acceptance and drained at output acceptance.
module tb_narrow_saturate;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] data_i;
   logic [2:0]  mode_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [15:0] data_o;
   logic        ovf_o;
   logic        clr_cnt_i;
   logic [7:0]  ovf_cnt_o;

   narrow_saturate dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .data_i      (data_i),
      .mode_i      (mode_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .data_o      (data_o),
      .ovf_o       (ovf_o),
      .clr_cnt_i   (clr_cnt_i),
      .ovf_cnt_o   (ovf_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [15:0] data;
      logic        ovf;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] din;
      logic [2:0]  mode;
      logic [15:0] dout;
      logic        ovf;
   } vec_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          exp_cnt = 0;
   bit          lat_exact = 1'b0;
   logic [15:0] exp_in_data;
   logic        exp_in_ovf;
   logic [15:0] held;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference narrowing written from the arithmetic definition.
   function automatic logic [16:0] model(input logic [31:0] d, input logic [2:0] m);
      if (m == 3'b001)
         return (d > 32'd65535) ? {16'hFFFF, 1'b1} : {d[15:0], 1'b0};
      if (m == 3'b010)
         return {d[15:0], 1'b0};
      if ($signed(d) > 32'sd32767)  return {16'h7FFF, 1'b1};
      if ($signed(d) < -32'sd32768) return {16'h8000, 1'b1};
      return {d[15:0], 1'b0};
   endfunction

   task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] m,
                        input logic [15:0] ed, input logic eo);
      in_valid_i  = v;
      data_i      = d;
      mode_i      = m;
      exp_in_data = ed;
      exp_in_ovf  = eo;
   endtask

   // One clock: resolve handshakes before the edge, update the model, check after.
   task automatic step();
      logic acc_in, acc_out, rst_s;
      exp_t e;
      #1;
      rst_s   = rst_i;
      acc_in  = 1'b0;
      acc_out = 1'b0;
      if (!rst_s) begin
         check("in_ready_in_reset", {31'd0, in_ready_o}, 32'd0);
      end else begin
         acc_in  = in_valid_i && in_ready_o;
         acc_out = out_valid_o && out_ready_i;
      end
      if (acc_out) begin
         tests++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_output: observed data %0h with %0d expected entries", data_o, 0);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("data", {16'd0, data_o}, {16'd0, e.data});
            check("ovf", {31'd0, ovf_o}, {31'd0, e.ovf});
            if (lat_exact) check("latency", cyc - e.cyc, 32'd2);
            if (e.ovf && exp_cnt != 255) exp_cnt++;
         end
      end
      if (clr_cnt_i || !rst_s) exp_cnt = 0;
      if (!rst_s) sb.delete();
      if (acc_in) sb.push_back('{exp_in_data, exp_in_ovf, cyc});
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
      check("ovf_cnt", {24'd0, ovf_cnt_o}, exp_cnt);
      if (!rst_s) check("out_valid_after_reset", {31'd0, out_valid_o}, 32'd0);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check("drain_timeout", sb.size(), 32'd0);
   endtask

   vec_t dir_v[9] = '{
      '{32'h0000_7FFF, 3'b000, 16'h7FFF, 1'b0},
      '{32'h0000_8000, 3'b000, 16'h7FFF, 1'b1},
      '{32'hFFFF_8000, 3'b000, 16'h8000, 1'b0},
      '{32'hFFFF_7FFF, 3'b000, 16'h8000, 1'b1},
      '{32'h0000_1234, 3'b000, 16'h1234, 1'b0},
      '{32'h0000_FFFF, 3'b001, 16'hFFFF, 1'b0},
      '{32'h0001_0000, 3'b001, 16'hFFFF, 1'b1},
      '{32'hFFFF_FFFF, 3'b001, 16'hFFFF, 1'b1},
      '{32'h1234_5678, 3'b010, 16'h5678, 1'b0}
   };

   initial begin
      logic [16:0] r;
      logic [31:0] rd;
      logic [2:0]  rm;

      rst_i       = 1'b0;
      out_ready_i = 1'b0;
      clr_cnt_i   = 1'b0;
      drive(1'b0, 32'd0, 3'b000, 16'd0, 1'b0);

      // Reset state
      step();
      step();
      check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("rst_data", {16'd0, data_o}, 32'h0);
      check("rst_ovf", {31'd0, ovf_o}, 32'd0);
      rst_i = 1'b1;
      #1 check("in_ready_after_reset", {31'd0, in_ready_o}, 32'd1);

      // Directed modes at full throughput: exact 2-edge latency
      lat_exact   = 1'b1;
      out_ready_i = 1'b1;
      foreach (dir_v[i]) begin
         drive(1'b1, dir_v[i].din, dir_v[i].mode, dir_v[i].dout, dir_v[i].ovf);
         step();
      end
      drive(1'b0, 32'd0, 3'b000, 16'd0, 1'b0);
      drain(10);

      // Backpressure: A and B absorbed, C waits, data_o holds A
      lat_exact   = 1'b0;
      out_ready_i = 1'b0;
      drive(1'b1, 32'h0000_0001, 3'b000, 16'h0001, 1'b0);
      step();
      drive(1'b1, 32'h0001_0000, 3'b001, 16'hFFFF, 1'b1);
      step();
      drive(1'b1, 32'h1234_5678, 3'b010, 16'h5678, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
         check("bp_out_valid", {31'd0, out_valid_o}, 32'd1);
         check("bp_data_hold", {16'd0, data_o}, 32'h0001);
         step();
      end
      check("bp_queue_depth", sb.size(), 32'd2);
      out_ready_i = 1'b1;
      step();
      drive(1'b0, 32'd0, 3'b000, 16'd0, 1'b0);
      drain(10);

      // Random words, modes and consumer stalls
      for (int k = 0; k < 40; k++) begin
         rd = $urandom();
         if (k % 3 == 0) rd = {{17{rd[31]}}, rd[14:0]} ^ {16'h0000, rd[31:16]};
         rm = 3'($urandom_range(0, 7));
         r  = model(rd, rm);
         drive(1'($urandom_range(0, 1)), rd, rm, r[16:1], r[0]);
         out_ready_i = 1'($urandom_range(0, 3) != 0);
         step();
      end
      drive(1'b0, 32'd0, 3'b000, 16'd0, 1'b0);
      out_ready_i = 1'b1;
      drain(10);

      // Counter saturation
      lat_exact = 1'b1;
      for (int k = 0; k < 300; k++) begin
         drive(1'b1, 32'h0001_0000, 3'b000, 16'h7FFF, 1'b1);
         step();
      end
      drive(1'b0, 32'd0, 3'b000, 16'd0, 1'b0);
      drain(10);
      check("cnt_saturated", {24'd0, ovf_cnt_o}, 32'hFF);

      // Clear coincident with an overflowed acceptance
      drive(1'b1, 32'h8000_0000, 3'b000, 16'h8000, 1'b1);
      step();
      drive(1'b0, 32'd0, 3'b000, 16'd0, 1'b0);
      step();
      #1 check("clr_out_valid", {31'd0, out_valid_o}, 32'd1);
      clr_cnt_i = 1'b1;
      step();
      clr_cnt_i = 1'b0;
      check("cnt_cleared", {24'd0, ovf_cnt_o}, 32'd0);

      // Mid-stream reset with two words in flight
      lat_exact   = 1'b0;
      out_ready_i = 1'b0;
      drive(1'b1, 32'h0002_0000, 3'b001, 16'hFFFF, 1'b1);
      step();
      drive(1'b1, 32'h0000_0042, 3'b000, 16'h0042, 1'b0);
      step();
      drive(1'b0, 32'd0, 3'b000, 16'd0, 1'b0);
      step();
      rst_i       = 1'b0;
      out_ready_i = 1'b1;
      step();
      check("mid_rst_cnt", {24'd0, ovf_cnt_o}, 32'd0);
      rst_i = 1'b1;
      #1 check("in_ready_after_mid_rst", {31'd0, in_ready_o}, 32'd1);
      lat_exact = 1'b1;
      drive(1'b1, 32'h0000_00A5, 3'b000, 16'h00A5, 1'b0);
      step();
      drive(1'b0, 32'd0, 3'b000, 16'd0, 1'b0);
      step();
      #1 check("post_rst_out_valid", {31'd0, out_valid_o}, 32'd1);
      for (int k = 0; k < 4; k++) step();
      check("post_rst_single_output", sb.size(), 32'd0);
      check("post_rst_idle", {31'd0, out_valid_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/narrow_saturate.md
# narrow_saturate

Two-stage elastic pipeline that narrows 32-bit datapath values to 16 bits, the inverse of the immediate widening path. Modes: signed saturation, unsigned saturation and plain truncation, each with an overflow flag. Sits between the ALU result bus and halfword consumers such as store-halfword packing and 16-bit result ports. Also keeps a sticky count of saturation events for debug readout.

## Interface
- No parameters; widths are fixed at 32 in / 16 out, counter 8 bits.
- clk_i  input  1  rising-edge clock.
- rst_i  input  1  synchronous reset, active-low: sampled on rising clk_i, 0 = reset.
- in_valid_i  input  1  input word present.
- in_ready_o  output  1  block accepts input this cycle.
- data_i  input  32  value to narrow.
- mode_i  input  3  3'b001 unsigned saturate; 3'b010 truncate; all other codes signed saturate.
- out_valid_o  output  1  result present.
- out_ready_i  input  1  consumer accepts result.
- data_o  output  16  narrowed result.
- ovf_o  output  1  result was clamped; qualified by out_valid_o.
- clr_cnt_i  input  1  clear overflow counter.
- ovf_cnt_o  output  8  saturating count of overflowed results accepted at the output.

## Operation
- Input accepted on in_valid_i && in_ready_o. Output accepted on out_valid_o && out_ready_i.
- Stage S1 registers data_i and mode_i, then computes the narrowed value and overflow flag combinationally from the registered copy. Stage S2 is the output register driving data_o, ovf_o and out_valid_o.
- Signed saturate:
  - data_i > 32'sd32767: result 16'h7FFF, ovf 1.
  - data_i < -32'sd32768: result 16'h8000, ovf 1.
  - Otherwise data_i[15:0], ovf 0.
  - In-range test: data_i[31:15] all 0 or all 1.
- Unsigned saturate: data_i[31:16] != 0 gives 16'hFFFF, ovf 1. Otherwise data_i[15:0], ovf 0.
- Truncate: data_i[15:0], ovf always 0.
- Mode is captured with the data and travels with it; changing mode_i never affects words already accepted.
- S2 loads from S1 when S1 is valid and S2 is empty or being consumed this cycle.
- S1 loads from the input when S1 is empty or moving to S2 this cycle.
- in_ready_o = rst_i && (!s1_valid || !s2_valid || out_ready_i). It is combinational, with no dependency on in_valid_i.
- Counter:
  - Increments by 1 on each output acceptance with ovf_o = 1.
  - Holds at 8'hFF.
  - clr_cnt_i forces 0 next cycle and wins over a simultaneous increment.

## Timing
- Reset, sampled at the edge with rst_i = 0:
  - s1_valid = s2_valid = 0.
  - out_valid_o = 0, data_o = 16'h0000, ovf_o = 0, ovf_cnt_o = 0.
  - in_ready_o = 0 while rst_i = 0.
  - Reset mid-operation discards all in-flight words; no partial output appears afterwards.
- Latency: a word accepted at edge N is shown on out_valid_o/data_o after edge N+1 (2 registers). It is consumable at edge N+2 at the earliest.
- Throughput: 1 word per cycle while out_ready_i stays 1.
- Backpressure:
  - With out_ready_i = 0, the block absorbs up to 2 words (S1 + S2). in_ready_o then falls to 0 in the same cycle S1 becomes occupied behind a full S2.
  - While out_valid_o = 1 and out_ready_i = 0, data_o and ovf_o hold stable.
  - out_valid_o never drops without an acceptance.
- When full and out_ready_i rises, one input and one output can transfer in the same cycle. There is no bubble and no loss.
- Empty pipeline: out_valid_o = 0; data_o keeps its last value, which is don't-care.

## Test plan
- Signed mode (3'b000), out_ready_i = 1, inputs 32'h00007FFF, 32'h00008000, 32'hFFFF8000, 32'hFFFF7FFF, 32'h00001234 -> outputs in order 7FFF/0, 7FFF/1, 8000/0, 8000/1, 1234/0 (data/ovf). Each output appears 2 edges after its input.
- Unsigned mode (3'b001): 32'h0000FFFF -> FFFF/0; 32'h00010000 -> FFFF/1; 32'hFFFFFFFF -> FFFF/1. Truncate mode (3'b010): 32'h12345678 -> 5678/0.
- Backpressure:
  - Hold out_ready_i = 0 and stream 3 words A, B, C with in_valid_i = 1. A and B are accepted; in_ready_o = 0 while C waits; data_o stays = A.
  - Raise out_ready_i: outputs A, B, C in order, one per cycle, none dropped or duplicated.
- Counter:
  - Send 300 signed inputs of 32'h00010000 -> ovf_cnt_o stops at 8'hFF.
  - Pulse clr_cnt_i in the same cycle as an overflowed output acceptance -> ovf_cnt_o = 0 next cycle.
- Reset mid-stream: with 2 words in flight, drive rst_i = 0 for 1 cycle.
  - During and after reset: out_valid_o = 0, ovf_cnt_o = 0, in_ready_o = 0 while rst_i = 0.
  - After release: in_ready_o = 1, and the next input produces exactly 1 output 2 edges later.
